// File: rtl/qspi_mem_responder_if.sv
// Quad-SPI target pins plus byte-wide memory port of the QSPI RAM responder.
interface qspi_mem_responder_if #(
  parameter int unsigned ADDR_BITS = 24
);
  logic                 spi_clk;
  logic                 spi_select;
  logic [3:0]           spi_data_in;
  logic [3:0]           spi_data_out;
  logic [3:0]           spi_data_oe;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_re;
  logic [7:0]           mem_rdata;
  logic                 mem_we;
  logic [7:0]           mem_wdata;

  modport slave (
    input  spi_clk, spi_select, spi_data_in, mem_rdata,
    output spi_data_out, spi_data_oe, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output spi_clk, spi_select, spi_data_in, mem_rdata,
    input  spi_data_out, spi_data_oe, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/qspi_mem_responder.sv
// QSPI RAM target for the TinyQV controller: decodes 0x02 write / 0x0B read with an
// oversampled spi_clk and drives a byte-wide memory port with one-cycle strobes.
module qspi_mem_responder #(
  parameter int unsigned ADDR_BITS    = 24,
  parameter int unsigned DUMMY_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  qspi_mem_responder_if.slave bus,
  output logic                busy
);
  localparam int unsigned DC_W = (DUMMY_CYCLES > 1) ? $clog2(DUMMY_CYCLES) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CMD    = 3'd1;
  localparam logic [2:0] ADDR   = 3'd2;
  localparam logic [2:0] DUMMY  = 3'd3;
  localparam logic [2:0] RDATA  = 3'd4;
  localparam logic [2:0] WDATA  = 3'd5;
  localparam logic [2:0] IGNORE = 3'd6;

  logic [2:0]           state_q, state_d;
  logic                 clk_q, sel_q, re_dly_q;
  logic [19:0]          shift_q, shift_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [DC_W-1:0]      dum_q, dum_d;
  logic                 is_read_q, is_read_d;
  logic                 lo_q, lo_d;
  logic [3:0]           whi_q, whi_d;
  logic [7:0]           cur_q, cur_d, next_q, next_d;
  logic                 rd_next_q, rd_next_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [3:0]           dout_q, dout_d, oe_q, oe_d;
  logic                 busy_q, busy_d;

  logic                 rise, fall, sel_fall;
  logic [23:0]          nib_word;
  logic [7:0]           cur_val, next_val;

  // Next-state and datapath decode; deselect overrides everything else.
  always_comb begin
    rise      = bus.spi_clk && !clk_q;
    fall      = !bus.spi_clk && clk_q;
    sel_fall  = !bus.spi_select && sel_q;
    nib_word  = {shift_q, bus.spi_data_in};
    // Forward read data arriving this cycle so back-to-back nibbles never see stale bytes.
    cur_val   = (re_dly_q && !rd_next_q) ? bus.mem_rdata : cur_q;
    next_val  = (re_dly_q && rd_next_q)  ? bus.mem_rdata : next_q;

    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    dum_d     = dum_q;
    is_read_d = is_read_q;
    lo_d      = lo_q;
    whi_d     = whi_q;
    cur_d     = cur_q;
    next_d    = next_q;
    rd_next_d = rd_next_q;
    addr_d    = addr_q;
    mem_re_d  = 1'b0;
    mem_we_d  = 1'b0;
    wdata_d   = wdata_q;
    dout_d    = dout_q;
    oe_d      = (state_q == RDATA) ? oe_q : 4'h0;

    if (re_dly_q && (state_q == DUMMY || state_q == RDATA)) begin
      if (rd_next_q) next_d = bus.mem_rdata;
      else           cur_d  = bus.mem_rdata;
    end
    // Write address advances the cycle after the strobe.
    if (mem_we_q) addr_d = addr_q + ADDR_BITS'(1);

    if (bus.spi_select) begin
      state_d = IDLE;
      oe_d    = 4'h0;
    end else begin
      unique case (state_q)
        IDLE: if (sel_fall) begin
          state_d = CMD;
          cnt_d   = 3'd0;
        end
        CMD: if (rise) begin
          shift_d = nib_word[19:0];
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd1) begin
            cnt_d = 3'd0;
            case (nib_word[7:0])
              8'h02:   begin state_d = ADDR; is_read_d = 1'b0; end
              8'h0B:   begin state_d = ADDR; is_read_d = 1'b1; end
              default: state_d = IGNORE;
            endcase
          end
        end
        ADDR: if (rise) begin
          shift_d = nib_word[19:0];
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd5) begin
            cnt_d  = 3'd0;
            addr_d = ADDR_BITS'(nib_word);
            lo_d   = 1'b0;
            dum_d  = '0;
            if (is_read_q) begin
              state_d   = DUMMY;
              mem_re_d  = 1'b1;
              rd_next_d = 1'b0;
            end else begin
              state_d = WDATA;
            end
          end
        end
        DUMMY: if (rise) begin
          if (dum_q == DC_W'(DUMMY_CYCLES - 1)) begin
            state_d = RDATA;
            lo_d    = 1'b0;
          end else begin
            dum_d = dum_q + DC_W'(1);
          end
        end
        RDATA: if (fall) begin
          oe_d = 4'hF;
          if (!lo_q) begin
            dout_d    = cur_val[7:4];
            addr_d    = addr_q + ADDR_BITS'(1);
            mem_re_d  = 1'b1;
            rd_next_d = 1'b1;
            lo_d      = 1'b1;
          end else begin
            dout_d = cur_val[3:0];
            cur_d  = next_val;
            lo_d   = 1'b0;
          end
        end
        WDATA: if (rise) begin
          if (!lo_q) begin
            whi_d = bus.spi_data_in;
            lo_d  = 1'b1;
          end else begin
            wdata_d  = {whi_q, bus.spi_data_in};
            mem_we_d = 1'b1;
            lo_d     = 1'b0;
          end
        end
        IGNORE: state_d = IGNORE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_q     <= 1'b0;
      sel_q     <= 1'b0;
      re_dly_q  <= 1'b0;
      shift_q   <= '0;
      cnt_q     <= '0;
      dum_q     <= '0;
      is_read_q <= 1'b0;
      lo_q      <= 1'b0;
      whi_q     <= '0;
      cur_q     <= '0;
      next_q    <= '0;
      rd_next_q <= 1'b0;
      addr_q    <= '0;
      mem_re_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      wdata_q   <= '0;
      dout_q    <= '0;
      oe_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_q     <= bus.spi_clk;
      sel_q     <= bus.spi_select;
      re_dly_q  <= mem_re_q;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      dum_q     <= dum_d;
      is_read_q <= is_read_d;
      lo_q      <= lo_d;
      whi_q     <= whi_d;
      cur_q     <= cur_d;
      next_q    <= next_d;
      rd_next_q <= rd_next_d;
      addr_q    <= addr_d;
      mem_re_q  <= mem_re_d;
      mem_we_q  <= mem_we_d;
      wdata_q   <= wdata_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.spi_data_out = dout_q;
  assign bus.spi_data_oe  = oe_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_re       = mem_re_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_wdata    = wdata_q;
  assign busy             = busy_q;
endmodule

// File: tb/tb_qspi_mem_responder.sv
// Scoreboard bench for qspi_mem_responder: directed plan cases plus randomized transactions.
module tb_qspi_mem_responder;
  localparam int unsigned AW = 24;
  localparam int unsigned DC = 4;

  typedef struct packed {
    logic        is_we;
    logic [23:0] addr;
    logic [7:0]  data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  qspi_mem_responder_if #(.ADDR_BITS(AW)) bus ();

  qspi_mem_responder #(.ADDR_BITS(AW), .DUMMY_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  ev_t         exp_mem[$];
  logic [3:0]  exp_nib[$];
  logic [7:0]  wbuf[$];
  logic [7:0]  ref_mem[4096];
  logic [7:0]  ram[4096];
  logic        ram_init = 1'b0;
  logic        mon_sclk_q = 1'b0;

  function automatic logic [7:0] init_byte(input int unsigned a);
    return 8'((a * 37) ^ (a >> 4) ^ 32'h5A);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=%0h required=none t=%0t", name, act, $time);
  endtask

  // Environment RAM: one-cycle read latency, written by DUT strobes.
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_byte(32'(i));
      ram_init <= 1'b1;
    end else begin
      if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr[11:0]];
      if (bus.mem_we) ram[bus.mem_addr[11:0]] <= bus.mem_wdata;
    end
  end

  task automatic mon_mem(input logic is_we);
    ev_t e;
    if (exp_mem.size() == 0) begin
      unexpected(is_we ? "unexpected_we" : "unexpected_re", 32'(bus.mem_addr));
      return;
    end
    e = exp_mem.pop_front();
    check(is_we ? "we_kind" : "re_kind", 32'(is_we), 32'(e.is_we));
    check(is_we ? "we_addr" : "re_addr", 32'(bus.mem_addr), 32'(e.addr));
    if (is_we) check("we_data", 32'(bus.mem_wdata), 32'(e.data));
  endtask

  // Monitor: strobes and nibbles sampled where the controller would (spi_clk rise).
  always @(negedge clk) begin
    mon_sclk_q <= bus.spi_clk;
    if (!rst) begin
      if (bus.mem_re && bus.mem_we) unexpected("re_we_overlap", 32'(bus.mem_addr));
      if (bus.mem_we) mon_mem(1'b1);
      if (bus.mem_re) mon_mem(1'b0);
      if (bus.spi_clk && !mon_sclk_q && bus.spi_data_oe == 4'hF) begin
        if (exp_nib.size() == 0) unexpected("unexpected_nibble", 32'(bus.spi_data_out));
        else check("read_nibble", 32'(bus.spi_data_out), 32'(exp_nib.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_cycle(input logic [3:0] nib, input int hp);
    bus.spi_data_in = nib;
    bus.spi_clk     = 1'b1;
    repeat (hp) tick();
    bus.spi_clk     = 1'b0;
    repeat (hp) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int hp);
    spi_cycle(b[7:4], hp);
    spi_cycle(b[3:0], hp);
  endtask

  task automatic send_addr(input logic [23:0] a, input int hp);
    for (int i = 5; i >= 0; i--) spi_cycle(a[i*4 +: 4], hp);
  endtask

  task automatic begin_txn(input logic [7:0] cmd, input int hp);
    bus.spi_select = 1'b0;
    repeat (2) tick();
    check("busy_rise", 32'(busy), 32'd1);
    send_byte(cmd, hp);
  endtask

  task automatic end_txn();
    bus.spi_select = 1'b1;
    repeat (3) tick();
    check("busy_idle", 32'(busy), 32'd0);
    check("oe_idle", 32'(bus.spi_data_oe), 32'd0);
    check("mem_events_left", 32'(exp_mem.size()), 32'd0);
    check("nibbles_left", 32'(exp_nib.size()), 32'd0);
    exp_mem.delete();
    exp_nib.delete();
  endtask

  // Writes every byte of wbuf; partial adds one dangling nibble that must be discarded.
  task automatic do_write(input logic [23:0] a, input int hp, input bit partial);
    logic [23:0] ai;
    for (int i = 0; i < wbuf.size(); i++) begin
      ai = a + 24'(i);
      exp_mem.push_back('{1'b1, ai, wbuf[i]});
      ref_mem[ai[11:0]] = wbuf[i];
    end
    begin_txn(8'h02, hp);
    send_addr(a, hp);
    foreach (wbuf[i]) send_byte(wbuf[i], hp);
    if (partial) spi_cycle(4'($urandom), hp);
    end_txn();
  endtask

  // Reads nb bytes; nb == 0 aborts right after the first high nibble is driven.
  task automatic do_read(input logic [23:0] a, input int nb, input int hp);
    logic [23:0] ai;
    logic [7:0]  b;
    for (int i = 0; i <= nb + 1; i++) begin
      ai = a + 24'(i);
      exp_mem.push_back('{1'b0, ai, 8'h00});
    end
    for (int i = 0; i < nb; i++) begin
      ai = a + 24'(i);
      b  = ref_mem[ai[11:0]];
      exp_nib.push_back(b[7:4]);
      exp_nib.push_back(b[3:0]);
    end
    begin_txn(8'h0B, hp);
    send_addr(a, hp);
    repeat (DC) spi_cycle(4'h0, hp);
    for (int i = 0; i < 2 * nb; i++) spi_cycle(4'h0, hp);
    if (nb == 0) begin
      check("oe_before_abort", 32'(bus.spi_data_oe), 32'hF);
      bus.spi_select = 1'b1;
      tick();
      check("oe_after_abort", 32'(bus.spi_data_oe), 32'd0);
      check("busy_after_abort", 32'(busy), 32'd0);
    end
    end_txn();
  endtask

  task automatic do_unknown(input logic [7:0] cmd, input int hp);
    begin_txn(cmd, hp);
    repeat (10) spi_cycle(4'($urandom), hp);
    check("oe_ignore", 32'(bus.spi_data_oe), 32'd0);
    check("busy_ignore", 32'(busy), 32'd1);
    end_txn();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  c;
    logic [23:0] a;
    int          hp;
    bus.spi_clk     = 1'b0;
    bus.spi_select  = 1'b0;
    bus.spi_data_in = 4'h0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(32'(i));

    // Reset with select low and spi_clk toggling.
    repeat (2) begin
      @(posedge clk);
      #1;
      bus.spi_clk = ~bus.spi_clk;
    end
    rst = 1'b0;
    tick();
    check("rst_dout", 32'(bus.spi_data_out), 32'd0);
    check("rst_oe", 32'(bus.spi_data_oe), 32'd0);
    check("rst_re", 32'(bus.mem_re), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    // Select still low from before reset: nothing may be decoded.
    send_byte(8'h02, 1);
    send_addr(24'h000040, 1);
    check("busy_held_select", 32'(busy), 32'd0);
    end_txn();

    // Directed plan cases.
    wbuf = {8'hA5, 8'h3C};
    do_write(24'h000010, 1, 1'b0);
    do_read(24'h000010, 2, 1);
    do_read(24'hFFFFFF, 2, 1);
    do_unknown(8'h9F, 1);
    wbuf = {};
    do_write(24'h000020, 1, 1'b1);
    do_read(24'h000010, 1, 2);
    do_read(24'h000011, 0, 1);

    // Reset mid-write with select held low.
    begin_txn(8'h02, 1);
    send_addr(24'h000030, 1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    send_byte(8'h99, 1);
    check("busy_after_rst", 32'(busy), 32'd0);
    end_txn();

    // Randomized traffic.
    repeat (40) begin
      hp = int'($urandom_range(1, 3));
      a  = 24'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = 24'hFFFFF0 + 24'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
        0, 1: begin
          wbuf = {};
          repeat ($urandom_range(1, 4)) wbuf.push_back(8'($urandom));
          do_write(a, hp, 1'($urandom_range(0, 1)));
        end
        2, 3: do_read(a, int'($urandom_range(0, 4)), hp);
        default: begin
          do c = 8'($urandom); while (c == 8'h02 || c == 8'h0B);
          do_unknown(c, hp);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/qspi_mem_responder.md
# qspi_mem_responder

Synthesizable QSPI target that answers the quad-SPI RAM transactions issued by the TinyQV QSPI controller. It decodes command, address, dummy and data phases from one chip select and drives a simple byte-wide memory port. It serves as the RAM side of FPGA and simulation harnesses. All SPI inputs are synchronous to `clk`, and `spi_clk` is oversampled, so the block uses a single clock domain.

## Interface

Parameters:
- `ADDR_BITS`, default 24: width of the memory address. Must be ≤ 24. Only the low `ADDR_BITS` bits of the received address are used.
- `DUMMY_CYCLES`, default 4: number of SPI clock cycles between the address phase and the first read-data nibble. Must be ≥ 1.

Ports (clock and reset first):
- `clk`, input, 1 bit: system clock; the only clock in the block.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `spi_clk`, input, 1 bit: SPI clock from the controller. Idles low. Each level lasts ≥ 1 `clk` cycle, so the SPI period is ≥ 2 `clk` cycles.
- `spi_select`, input, 1 bit: chip select, active low.
- `spi_data_in`, input, 4 bits: quad data from the controller.
- `spi_data_out`, output, 4 bits: quad read data.
- `spi_data_oe`, output, 4 bits: output enables. `4'hF` while driving read data, otherwise `4'h0`.
- `mem_addr`, output, `ADDR_BITS` bits: registered byte address.
- `mem_re`, output, 1 bit: one-cycle read strobe. `mem_rdata` is valid exactly one cycle later.
- `mem_rdata`, input, 8 bits: read data.
- `mem_we`, output, 1 bit: one-cycle write strobe.
- `mem_wdata`, output, 8 bits: write data, valid while `mem_we` is high.
- `busy`, output, 1 bit: high while a transaction is in progress (state is not IDLE).

## Operation

Edge detection:
- `spi_clk` is registered as `clk_q`.
- A rising edge is `spi_clk && !clk_q`; a falling edge is `!spi_clk && clk_q`.
- Input nibbles are sampled on rising-edge cycles. Outputs change only on falling-edge cycles.

Framing:
- A falling `spi_select` starts a transaction in state CMD.
- Every field is sent most-significant nibble first.
- Command: 2 nibbles. Address: 6 nibbles (24 bits).

States:
- **IDLE**: waiting for `spi_select` low.
- **CMD**: collects the 8-bit command. `0x02` goes to ADDR with write set. `0x0B` goes to ADDR with read set. Any other value goes to IGNORE.
- **ADDR**: collects 6 nibbles into the address register.
  - Write: goes to WDATA.
  - Read: goes to DUMMY. In the cycle after the 6th nibble is captured, `mem_re` = 1 with `mem_addr` = the received address. The following cycle, `mem_rdata` is loaded into `cur_byte`.
- **DUMMY**: counts `DUMMY_CYCLES` rising edges, then goes to RDATA.
- **RDATA**: on each falling edge, the next nibble is driven and `spi_data_oe` = `4'hF`. The nibbles alternate as follows:
  - High nibble of `cur_byte`. In the same cycle the address increments, and in the next cycle `mem_re` = 1 for the new address. The result is loaded into `next_byte`.
  - Low nibble of `cur_byte`.
  - Then `cur_byte` <= `next_byte`, and the sequence repeats with its high nibble.
- **WDATA**: each pair of captured nibbles forms one byte. In the cycle after the low nibble is captured:
  - `mem_we` = 1, `mem_wdata` = the byte, `mem_addr` = the current address.
  - The address then increments.
- **IGNORE**: no memory activity and outputs disabled until deselect.

Rules:
- The address wraps modulo 2^`ADDR_BITS`.
- `spi_select` high in any state, in any cycle, returns the block to IDLE. This takes priority over simultaneous edges and aborts the transaction.
  - `spi_data_oe` = `4'h0` from the next cycle.
  - A partially received write byte is discarded, and `mem_we` is never asserted for it.
  - An outstanding `mem_re` completes, but its data is dropped.

## Timing

- Reset values: `spi_data_out` = 0, `spi_data_oe` = 0, `mem_re` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `busy` = 0. State is IDLE and `clk_q` = 0.
- Reset mid-transaction behaves like an abort. It is honoured even while `spi_select` is still low; the block then waits for `spi_select` to go high and low again before decoding.
- `busy` goes high in the cycle after `spi_select` is sampled low.
- Read latency: the first data nibble is driven on the falling edge after the `DUMMY_CYCLES`-th dummy rising edge. With `DUMMY_CYCLES` ≥ 1 and an SPI period ≥ 2 clk, `cur_byte` is always loaded in time. `next_byte` is always ready before the next high nibble.
- `mem_we` asserts 1 cycle after the rising edge that captured the low nibble. `mem_re` asserts 1 cycle after the triggering edge.
- `mem_re` and `mem_we` are never high in the same cycle.

## Test plan

- **Reset:** hold `rst` 2 cycles with `spi_select` low and `spi_clk` toggling -> all outputs 0, no strobes, `busy` = 0.
- **Write:** select, send `0x02`, address `0x000010`, data `0xA5 0x3C`, deselect -> `mem_we` pulses with (addr `0x10`, `0xA5`) then (addr `0x11`, `0x3C`), exactly 2 pulses.
- **Read:** memory holds `0x10`=`0xA5`, `0x11`=`0x3C`. Send `0x0B`, address `0x000010`, 4 dummy cycles, 4 data clocks -> sampled nibbles A, 5, 3, C with `spi_data_oe` = `F`; `mem_re` addresses `0x10` then `0x11`.
- **Address wrap:** read at address `0xFFFFFF` for 2 bytes -> `mem_re` addresses `0xFFFFFF` then `0x000000`.
- **Unknown command and aborted write:**
  - Command `0x9F` followed by 10 clocks -> no `mem_re`/`mem_we`, `spi_data_oe` = 0.
  - Write aborted after 1 data nibble -> no `mem_we`; the next transaction decodes normally.
- **Abort mid-read:** deselect after the high nibble -> `spi_data_oe` = 0 on the next cycle, `busy` = 0, state IDLE.
